// File: rtl/replay_pkg.sv
// Shared types and helpers for the transmit replay buffer: FSM states,
// pointer-width calculation and modular sequence-number distance.
package replay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    REPLAY
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Distance from the head entry to the word after ackSeq, modulo 2**seqW.
  function automatic logic [31:0] seqDelta(input logic [31:0] ackSeq,
                                           input logic [31:0] headSeq,
                                           input int          seqW);
    logic [31:0] mask;
    mask = (32'd1 << seqW) - 32'd1;
    return (ackSeq - headSeq + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/replay_ram.sv
// Simple dual-port RAM: synchronous write, registered read, storage not reset.
module replay_ram
  import replay_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data only moves on a read, so the output word holds while stalled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/replay_buffer.sv
// Transmit replay buffer: sequence-tags outgoing words, holds them until ACKed
// and retransmits every unacknowledged word in order after a NAK.
module replay_buffer
  import replay_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 12,
  localparam int PW    = clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [SEQ_W-1:0]  out_seq_o,
  input  logic              out_ready_i,
  input  logic              ack_valid_i,
  input  logic              nak_valid_i,
  input  logic [SEQ_W-1:0]  ackn_seq_i,
  output logic              ack_err_o,
  output logic              replay_active_o,
  output logic [PW-1:0]     occupancy_o
);

  localparam int AW = PW - 1;

  logic [PW-1:0]    head_q, head_d, done_q, done_d, rd_q, rd_d, tail_q, tail_d;
  logic [PW-1:0]    replayEnd_q, replayEnd_d, occ_q;
  logic [SEQ_W-1:0] headSeq_q, headSeq_d;
  logic             outValid_q, outValid_d, ackErr_q, ackErr_d;
  state_e           state_q, state_d;

  logic [PW-1:0]    fill, window, outOffset;
  logic [31:0]      delta32;
  logic             wrEn, rdEn, hsk, inWindow, nakOk, ackOk, seqErr;

  assign fill      = tail_q - head_q;
  assign window    = done_q - head_q;
  assign outOffset = done_q - head_q;
  assign wrEn      = in_valid_i && (fill != PW'(DEPTH));
  assign hsk       = outValid_q && out_ready_i;
  assign delta32   = seqDelta(32'(ackn_seq_i), 32'(headSeq_q), SEQ_W);
  assign inWindow  = delta32 <= 32'(window);
  assign nakOk     = nak_valid_i && inWindow;
  assign ackOk     = ack_valid_i && !nak_valid_i && inWindow && (delta32 != 32'd0);
  assign seqErr    = (ack_valid_i || nak_valid_i) && !inWindow;
  // A NAK flushes the output stage, so no read is launched in that cycle.
  assign rdEn      = (!outValid_q || out_ready_i) && (rd_q != tail_q) && !nakOk;

  always_comb begin
    head_d      = head_q;
    done_d      = done_q;
    rd_d        = rd_q;
    tail_d      = tail_q;
    replayEnd_d = replayEnd_q;
    headSeq_d   = headSeq_q;
    outValid_d  = outValid_q;
    ackErr_d    = seqErr;
    state_d     = state_q;

    if (wrEn) tail_d = tail_q + PW'(1);
    if (hsk) begin
      done_d     = done_q + PW'(1);
      outValid_d = 1'b0;
    end
    if (rdEn) begin
      rd_d       = rd_q + PW'(1);
      outValid_d = 1'b1;
    end

    if (nakOk) begin
      head_d      = head_q + PW'(delta32);
      headSeq_d   = headSeq_q + SEQ_W'(delta32);
      rd_d        = head_d;
      done_d      = head_d;
      outValid_d  = 1'b0;
      replayEnd_d = done_q;
    end else if (ackOk) begin
      head_d    = head_q + PW'(delta32);
      headSeq_d = headSeq_q + SEQ_W'(delta32);
    end

    if (nakOk) begin
      if (head_d != done_q)      state_d = REPLAY;
      else if (rd_d != tail_d)   state_d = SEND;
      else                       state_d = IDLE;
    end else if (state_q == REPLAY && done_d != replayEnd_q) begin
      state_d = REPLAY;
    end else if (rd_d == tail_d && !outValid_d) begin
      state_d = IDLE;
    end else begin
      state_d = SEND;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      done_q      <= '0;
      rd_q        <= '0;
      tail_q      <= '0;
      replayEnd_q <= '0;
      headSeq_q   <= '0;
      outValid_q  <= 1'b0;
      ackErr_q    <= 1'b0;
      occ_q       <= '0;
      state_q     <= IDLE;
    end else begin
      head_q      <= head_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      tail_q      <= tail_d;
      replayEnd_q <= replayEnd_d;
      headSeq_q   <= headSeq_d;
      outValid_q  <= outValid_d;
      ackErr_q    <= ackErr_d;
      occ_q       <= tail_d - head_d;
      state_q     <= state_d;
    end
  end

  replay_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (wrEn),
    .waddr_i(tail_q[AW-1:0]),
    .wdata_i(in_data_i),
    .re_i   (rdEn),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(out_data_o)
  );

  // The presented word always sits at done, so its sequence follows from head.
  assign out_seq_o       = headSeq_q + SEQ_W'(outOffset);
  assign in_ready_o      = (fill != PW'(DEPTH));
  assign out_valid_o     = outValid_q;
  assign ack_err_o       = ackErr_q;
  assign replay_active_o = (state_q == REPLAY);
  assign occupancy_o     = occ_q;

endmodule

// File: tb/tb_replay_buffer.sv
// Scoreboard bench for replay_buffer: stimulus queues expected words, a
// negedge monitor compares each word the DUT hands downstream.
module tb_replay_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 12;
  localparam int PW     = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [11:0] seq;
    logic        replay;
  } exp_t;

  logic              clk_i;
  logic              rst_ni;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [SEQ_W-1:0]  out_seq_o;
  logic              out_ready_i;
  logic              ack_valid_i;
  logic              nak_valid_i;
  logic [SEQ_W-1:0]  ackn_seq_i;
  logic              ack_err_o;
  logic              replay_active_o;
  logic [PW-1:0]     occupancy_o;

  exp_t        expQ[$];
  exp_t        monEntry;
  logic [15:0] dataBySeq [4096];
  logic [11:0] writeSeq;
  logic [11:0] lastPopSeq;
  int          checkCount;
  int          passCount;
  int          popCount;
  int          errSeen;
  int          written;
  int          cyc;

  replay_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .out_seq_o      (out_seq_o),
    .out_ready_i    (out_ready_i),
    .ack_valid_i    (ack_valid_i),
    .nak_valid_i    (nak_valid_i),
    .ackn_seq_i     (ackn_seq_i),
    .ack_err_o      (ack_err_o),
    .replay_active_o(replay_active_o),
    .occupancy_o    (occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Every accepted handshake must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: got seq 0x%0h, required no output", out_seq_o);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("out_data", 32'(out_data_o), 32'(monEntry.data));
        checkOutput("out_seq", 32'(out_seq_o), 32'(monEntry.seq));
        checkOutput("out_replay", 32'(replay_active_o), 32'(monEntry.replay));
        lastPopSeq = monEntry.seq;
        popCount++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    ack_valid_i = 1'b0;
    nak_valid_i = 1'b0;
    ackn_seq_i  = '0;
    expQ.delete();
    writeSeq   = '0;
    lastPopSeq = '0;
    popCount   = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic applyStimulus(input bit doWrite, input logic [15:0] d, input bit doAck,
                               input bit doNak, input logic [11:0] s);
    if (doWrite) begin
      checkOutput("in_ready_write", 32'(in_ready_o), 32'd1);
      dataBySeq[writeSeq] = d;
      expQ.push_back(exp_t'{d, writeSeq, 1'b0});
      writeSeq = writeSeq + 12'd1;
    end
    in_valid_i  = doWrite;
    in_data_i   = d;
    ack_valid_i = doAck;
    nak_valid_i = doNak;
    ackn_seq_i  = s;
    tick();
    in_valid_i  = 1'b0;
    ack_valid_i = 1'b0;
    nak_valid_i = 1'b0;
  endtask

  // Words first..first+count-1 come back, ahead of anything still queued.
  task automatic pushReplay(input logic [11:0] first, input int count);
    logic [11:0] s;
    for (int i = count - 1; i >= 0; i--) begin
      s = first + 12'(i);
      expQ.push_front(exp_t'{dataBySeq[s], s, 1'b1});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain_timeout: %0d words outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount  = 0;
    passCount   = 0;
    out_ready_i = 1'b0;

    // Reset state, first-word latency, sequence tagging
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("rst_replay", 32'(replay_active_o), 32'd0);
    checkOutput("rst_ack_err", 32'(ack_err_o), 32'd0);
    out_ready_i = 1'b1;
    applyStimulus(1, 16'h000A, 0, 0, 12'd0);
    checkOutput("latency_1cyc", 32'(out_valid_o), 32'd0);
    applyStimulus(1, 16'h000F, 0, 0, 12'd0);
    checkOutput("latency_2cyc", 32'(out_valid_o), 32'd1);
    applyStimulus(1, 16'h0014, 0, 0, 12'd0);
    drain();
    checkOutput("occupancy_3", 32'(occupancy_o), 32'd3);

    // Full buffer refuses the ninth word; ACK drains it
    doReset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1, 16'h0100 + 16'(i), 0, 0, 12'd0);
    checkOutput("in_ready_full", 32'(in_ready_o), 32'd0);
    checkOutput("occupancy_full", 32'(occupancy_o), 32'd8);
    in_valid_i = 1'b1;
    in_data_i  = 16'hDEAD;
    tick();
    in_valid_i = 1'b0;
    checkOutput("occupancy_refused", 32'(occupancy_o), 32'd8);
    drain();
    applyStimulus(0, 16'h0, 1, 0, 12'd3);
    checkOutput("occupancy_ack3", 32'(occupancy_o), 32'd4);
    checkOutput("in_ready_ack3", 32'(in_ready_o), 32'd1);
    checkOutput("ack_err_ack3", 32'(ack_err_o), 32'd0);

    // NAK after seq 0..5 handshaked, seq 6 held on the output
    doReset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1, 16'h0200 + 16'(i), 0, 0, 12'd0);
    drain();
    out_ready_i = 1'b0;
    applyStimulus(1, 16'h0206, 0, 0, 12'd0);
    applyStimulus(1, 16'h0207, 0, 0, 12'd0);
    checkOutput("held_valid", 32'(out_valid_o), 32'd1);
    checkOutput("held_seq", 32'(out_seq_o), 32'd6);
    pushReplay(12'd3, 3);
    applyStimulus(0, 16'h0, 0, 1, 12'd2);
    checkOutput("nak_flush", 32'(out_valid_o), 32'd0);
    checkOutput("nak_replay", 32'(replay_active_o), 32'd1);
    checkOutput("nak_occupancy", 32'(occupancy_o), 32'd5);
    out_ready_i = 1'b1;
    drain();
    checkOutput("replay_done", 32'(replay_active_o), 32'd0);

    // Out-of-window ACK, then a good one
    applyStimulus(0, 16'h0, 1, 0, 12'd12);
    checkOutput("bad_ack_err", 32'(ack_err_o), 32'd1);
    checkOutput("bad_ack_occupancy", 32'(occupancy_o), 32'd5);
    checkOutput("bad_ack_out_valid", 32'(out_valid_o), 32'd0);
    tick();
    checkOutput("bad_ack_pulse", 32'(ack_err_o), 32'd0);
    applyStimulus(0, 16'h0, 1, 0, 12'd7);
    checkOutput("good_ack_occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("good_ack_err", 32'(ack_err_o), 32'd0);

    // Simultaneous ACK and NAK: NAK wins
    doReset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0300 + 16'(i), 0, 0, 12'd0);
    drain();
    pushReplay(12'd2, 2);
    applyStimulus(0, 16'h0, 1, 1, 12'd1);
    checkOutput("acknak_replay", 32'(replay_active_o), 32'd1);
    checkOutput("acknak_occupancy", 32'(occupancy_o), 32'd2);
    checkOutput("acknak_err", 32'(ack_err_o), 32'd0);
    drain();
    checkOutput("acknak_after_occ", 32'(occupancy_o), 32'd2);
    checkOutput("acknak_after_replay", 32'(replay_active_o), 32'd0);

    // Sequence wrap: 4097 words with periodic ACKs, last word carries seq 0
    doReset();
    out_ready_i = 1'b1;
    written = 0;
    cyc     = 0;
    errSeen = 0;
    while (written < 4097 && cyc < 20000) begin
      applyStimulus(cyc % 2 == 0, 16'(written) ^ 16'h5A5A,
                    (cyc % 4 == 3) && (popCount > 0), 0, lastPopSeq);
      if (ack_err_o) errSeen++;
      if (cyc % 2 == 0) written++;
      cyc++;
    end
    drain();
    checkOutput("wrap_ack_errs", 32'(errSeen), 32'd0);
    applyStimulus(0, 16'h0, 1, 0, 12'd0);
    checkOutput("wrap_ack0_err", 32'(ack_err_o), 32'd0);
    checkOutput("wrap_ack0_occ", 32'(occupancy_o), 32'd0);

    // Asynchronous reset in the middle of a replay
    doReset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1, 16'h0400 + 16'(i), 0, 0, 12'd0);
    drain();
    pushReplay(12'd1, 3);
    applyStimulus(0, 16'h0, 0, 1, 12'd0);
    checkOutput("midrst_replay_on", 32'(replay_active_o), 32'd1);
    tick();
    tick();
    rst_ni = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("midrst_replay", 32'(replay_active_o), 32'd0);
    checkOutput("midrst_occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("midrst_ack_err", 32'(ack_err_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
